// File: rtl/dmem_pkg.sv
// Shared types for the two-port data-memory arbiter.
// Feature macro used by dmem_arbiter: DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SIZE_W    = 2;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef logic port_idx_t;

  // Request captured at the accept edge; size kept raw so 2'b11 passes through.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [2:0] size_bytes(input size_t size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: on a tie the port that did not win last time wins.
module rr_arbiter_2
  import dmem_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_valid,
  input  port_idx_t            last_grant,
  output logic                 grant_valid_c,
  output port_idx_t            grant_idx_c
);

  always_comb begin
    grant_valid_c = |req_valid;
    grant_idx_c   = 1'b0;
    if (&req_valid) begin
      grant_idx_c = ~last_grant;
    end else if (req_valid[1]) begin
      grant_idx_c = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port data_memory between two requesters: accept -> access -> response.
// Optional request checking (alignment, size, range) enabled by DMEM_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_PORTS-1:0]           req_valid,
  output logic [NUM_PORTS-1:0]           req_ready,
  input  logic [NUM_PORTS-1:0]           req_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][SIZE_W-1:0] req_size,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           rsp_valid,
  input  logic [NUM_PORTS-1:0]           rsp_ready,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic                           mem_write_en,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [SIZE_W-1:0]              mem_store_size,
  output logic [DATA_W-1:0]              mem_store_data,
  input  logic [DATA_W-1:0]              mem_load_data
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int unsigned END_W = ADDR_W + 1;

  arb_state_t state_q, state_d;
  mem_req_t   lat_q;
  port_idx_t  winner_q;
  port_idx_t  last_grant_q;
  logic       grant_valid_c;
  port_idx_t  grant_idx_c;
  logic       accept;

  logic [END_W-1:0] end_addr;
  logic             misaligned;
  logic             out_of_range;
  logic             err_c;

  rr_arbiter_2 u_rr (
    .req_valid     (req_valid),
    .last_grant    (last_grant_q),
    .grant_valid_c (grant_valid_c),
    .grant_idx_c   (grant_idx_c)
  );

  // Request check on the latched request; folds to 0 when checking is disabled.
  always_comb begin
    end_addr     = {1'b0, lat_q.addr} + END_W'(size_bytes(size_t'(lat_q.size)));
    out_of_range = end_addr > END_W'(MEM_SIZE);
    misaligned   = ((lat_q.size == SIZE_HALF) && lat_q.addr[0])
                || ((lat_q.size == SIZE_WORD) && (lat_q.addr[1:0] != 2'b00))
                || (lat_q.size == 2'b11);
    err_c        = CHECK_EN & (misaligned | out_of_range);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    req_ready      = '0;
    rsp_valid      = '0;
    mem_write_en   = 1'b0;
    mem_addr       = '0;
    mem_store_size = '0;
    mem_store_data = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          accept                 = 1'b1;
          req_ready[grant_idx_c] = 1'b1;
          state_d                = ACCESS;
        end
      end
      ACCESS: begin
        mem_write_en   = lat_q.we & ~err_c;
        mem_addr       = lat_q.addr;
        mem_store_size = lat_q.size;
        mem_store_data = lat_q.wdata;
        state_d        = RESP;
      end
      RESP: begin
        rsp_valid[winner_q] = 1'b1;
        if (rsp_ready[winner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, grant history and response data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_q        <= '0;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        lat_q.we     <= req_we[grant_idx_c];
        lat_q.addr   <= req_addr[grant_idx_c];
        lat_q.size   <= req_size[grant_idx_c];
        lat_q.wdata  <= req_wdata[grant_idx_c];
        winner_q     <= grant_idx_c;
        last_grant_q <= grant_idx_c;
      end
      if (state_q == ACCESS) begin
        rsp_rdata <= (lat_q.we || err_c) ? '0 : mem_load_data;
        rsp_err   <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed data_memory model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][1:0]  req_size;
  logic [31:0] rsp_rdata, mem_addr, mem_store_data, mem_load_data;
  logic        rsp_err, mem_write_en;
  logic [1:0]  mem_store_size;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem [512];
  bit         mem_loaded = 1'b0;
  logic [8:0] la;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_SIZE(512)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_store_size(mem_store_size), .mem_store_data(mem_store_data),
    .mem_load_data(mem_load_data)
  );

  // Memory model: byte i starts as i; little-endian stores, asynchronous word read.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i);
      mem_loaded <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_addr[8:0]] <= mem_store_data[7:0];
      if (mem_store_size != 2'b00) mem[mem_addr[8:0] + 9'd1] <= mem_store_data[15:8];
      if (mem_store_size[1]) begin
        mem[mem_addr[8:0] + 9'd2] <= mem_store_data[23:16];
        mem[mem_addr[8:0] + 9'd3] <= mem_store_data[31:24];
      end
    end
  end

  always_comb begin
    la = mem_addr[8:0];
    mem_load_data = {mem[la + 9'd3], mem[la + 9'd2], mem[la + 9'd1], mem[la]};
  end

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [8:0] b;
    b = a[8:0];
    return {mem[b + 9'd3], mem[b + 9'd2], mem[b + 9'd1], mem[b]};
  endfunction

  // Issues one request on port p and takes its response; lat = cycles from accept to rsp_valid, -1 on timeout.
  task automatic run_req(input int p, input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, output int wait_cyc, output int lat,
                         output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = addr; req_size[p] = size; req_wdata[p] = wdata;
    #1;
    wait_cyc = 0;
    lat = -1; rdata = 'x; err = 1'bx;
    while (!req_ready[p] && wait_cyc < 20) begin @(posedge clk); #2; wait_cyc++; end
    if (!req_ready[p]) begin req_valid[p] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[p] = 1'b0; req_we[p] = ~we; req_addr[p] = $urandom(); req_wdata[p] = $urandom();
    #1;
    lat = 1;
    while (!rsp_valid[p] && lat < 20) begin @(posedge clk); #2; lat++; end
    if (!rsp_valid[p]) begin lat = -1; return; end
    rdata = rsp_rdata; err = rsp_err;
    rsp_ready[p] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[p] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_size = '0; req_wdata = '0; rsp_ready = '0;
    @(posedge clk); @(posedge clk); #2;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    vectors++; if ({rsp_rdata, rsp_err} !== 33'd0) begin miscompares++; $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_rdata, rsp_err); end
    vectors++; if ({mem_write_en, mem_addr, mem_store_size, mem_store_data} !== 67'd0) begin
      miscompares++; $display("FAIL reset_mem_bus: got we=%b addr=%h expected 0", mem_write_en, mem_addr); end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_arbitration();
    int grants[$];
    int last_g = -1;
    int nrsp = 0;
    logic [31:0] exp;
    @(posedge clk); #1;
    req_we = '0; req_size[0] = 2'b10; req_size[1] = 2'b10; req_addr[0] = 32'h0; req_addr[1] = 32'h4;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rsp_valid != 2'b00) begin
        nrsp++;
        vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL arb_grant_while_pending: got %b expected 00", req_ready); end
        if (last_g >= 0) begin
          exp = (last_g == 0) ? 32'h03020100 : 32'h07060504;
          vectors++; if (rsp_valid !== 2'(1 << last_g)) begin miscompares++; $display("FAIL arb_rsp_port: got %b expected %b", rsp_valid, 2'(1 << last_g)); end
          vectors++; if (rsp_rdata !== exp) begin miscompares++; $display("FAIL arb_rdata: got %h expected %h", rsp_rdata, exp); end
        end
      end
      if (req_ready == 2'b01) begin grants.push_back(0); last_g = 0; end
      else if (req_ready == 2'b10) begin grants.push_back(1); last_g = 1; end
      else if (req_ready != 2'b00) begin vectors++; miscompares++; $display("FAIL arb_onehot: got %b expected one-hot", req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0; rsp_ready = '0;
    vectors++; if (grants.size() !== 4) begin miscompares++; $display("FAIL arb_grant_count: got %0d expected 4", grants.size()); end
    vectors++; if (nrsp !== 4) begin miscompares++; $display("FAIL arb_rsp_count: got %0d expected 4", nrsp); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (k >= grants.size() || grants[k] !== (k % 2)) begin
        miscompares++; $display("FAIL arb_grant_order[%0d]: got %0d expected %0d", k, (k < grants.size()) ? grants[k] : -1, k % 2);
      end
    end
  endtask

  task automatic test_store_load();
    int w, lat; logic [31:0] rd; logic er;
    run_req(0, 1'b1, 32'h10, 2'b10, 32'hDEADBEEF, w, lat, rd, er);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL st_latency: got %0d expected 2", lat); end
    vectors++; if ({rd, er} !== 33'd0) begin miscompares++; $display("FAIL st_rsp: got %h/%b expected 0/0", rd, er); end
    vectors++; if (mword(32'h10) !== 32'hDEADBEEF) begin miscompares++; $display("FAIL st_mem: got %h expected deadbeef", mword(32'h10)); end
    run_req(0, 1'b0, 32'h10, 2'b10, 32'h0, w, lat, rd, er);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL ld_back_to_back_ready: got wait %0d expected 0", w); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ld_latency: got %0d expected 2", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_rdata: got %h expected deadbeef", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err: got %b expected 0", er); end
  endtask

  task automatic test_byte_merge();
    int w, lat; logic [31:0] rd; logic er;
    run_req(0, 1'b1, 32'h20, 2'b10, 32'h11223344, w, lat, rd, er);
    run_req(1, 1'b1, 32'h21, 2'b00, 32'h000000AB, w, lat, rd, er);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL byte_st_latency: got %0d expected 2", lat); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL byte_st_rdata: got %h expected 0", rd); end
    run_req(0, 1'b0, 32'h20, 2'b10, 32'h0, w, lat, rd, er);
    vectors++; if (rd !== 32'h1122AB44) begin miscompares++; $display("FAIL byte_merge_rdata: got %h expected 1122ab44", rd); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h20; req_size[0] = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_accept: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b10; req_we[1] = 1'b1; req_addr[1] = 32'h30; req_size[1] = 2'b10; req_wdata[1] = 32'h99999999;
    @(posedge clk); #2;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 01", c, rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h1122AB44) begin miscompares++; $display("FAIL bp_rdata[%0d]: got %h expected 1122ab44", c, rsp_rdata); end
      vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_req_ready[%0d]: got %b expected 00", c, req_ready); end
      vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL bp_mem_we[%0d]: got %b expected 0", c, mem_write_en); end
      @(posedge clk); #2;
    end
    rsp_ready[0] = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = '0;
    #1;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL bp_rsp_taken: got %b expected 00", rsp_valid); end
    vectors++; if (mword(32'h30) !== 32'h33323130) begin miscompares++; $display("FAIL bp_no_write: got %h expected 33323130", mword(32'h30)); end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h40; req_size[0] = 2'b10; req_wdata[0] = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    vectors++; if (mem_write_en !== 1'b1) begin miscompares++; $display("FAIL rst_access_we: got %b expected 1", mem_write_en); end
    #1 reset_n = 1'b0;
    #1;
    vectors++; if ({mem_write_en, mem_addr, mem_store_data} !== 65'd0) begin
      miscompares++; $display("FAIL rst_mem_bus: got we=%b addr=%h expected 0", mem_write_en, mem_addr); end
    vectors++; if ({rsp_valid, rsp_rdata, rsp_err} !== 35'd0) begin miscompares++; $display("FAIL rst_rsp: got %b/%h expected 0", rsp_valid, rsp_rdata); end
    @(posedge clk); #2;
    vectors++; if (mword(32'h40) !== 32'h43424140) begin miscompares++; $display("FAIL rst_no_write: got %h expected 43424140", mword(32'h40)); end
    #1 reset_n = 1'b1;
    @(posedge clk); #2;
    vectors++; if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_no_rsp: got %b expected 00", rsp_valid); end
    @(posedge clk); #1;
    req_we = '0; req_addr[0] = 32'h0; req_addr[1] = 32'h4; req_size[0] = 2'b10; req_size[1] = 2'b10; req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_first_grant: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    vectors++; if (rsp_valid !== 2'b01) begin miscompares++; $display("FAIL rst_rsp_port: got %b expected 01", rsp_valid); end
    vectors++; if (rsp_rdata !== 32'h03020100) begin miscompares++; $display("FAIL rst_rsp_rdata: got %h expected 03020100", rsp_rdata); end
    @(posedge clk); #1;
    rsp_ready = '0;
  endtask

  task automatic test_align_check();
    int w, lat; logic [31:0] rd; logic er;
    logic exp_err; logic [31:0] exp_ld, exp_w0;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_err = 1'b1; exp_ld = 32'h0; exp_w0 = 32'h03020100;
`else
    exp_err = 1'b0; exp_ld = 32'h0100FFFE; exp_w0 = 32'h77880100;
`endif
    run_req(0, 1'b0, 32'h1FE, 2'b10, 32'h0, w, lat, rd, er);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL chk_ld_latency: got %0d expected 2", lat); end
    vectors++; if (er !== exp_err) begin miscompares++; $display("FAIL chk_ld_err: got %b expected %b", er, exp_err); end
    vectors++; if (rd !== exp_ld) begin miscompares++; $display("FAIL chk_ld_rdata: got %h expected %h", rd, exp_ld); end
    run_req(1, 1'b1, 32'h2, 2'b10, 32'h55667788, w, lat, rd, er);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL chk_st_latency: got %0d expected 2", lat); end
    vectors++; if (er !== exp_err) begin miscompares++; $display("FAIL chk_st_err: got %b expected %b", er, exp_err); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL chk_st_rdata: got %h expected 0", rd); end
    vectors++; if (mword(32'h0) !== exp_w0) begin miscompares++; $display("FAIL chk_mem: got %h expected %h", mword(32'h0), exp_w0); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_store_load();
    test_byte_merge();
    test_backpressure();
    test_reset_midop();
    test_align_check();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
